ex_stage: RTL
=============

# ex_stage

Execute stage of the Lapido pipeline. It consumes the fields launched by the ID/EX pipeline register and computes the ALU result, the store data, and the branch/jump decision. Results are captured into the EX/MEM-side output register. Multiply and divide run on an iterative unit; while one is in progress, `stall` holds the upstream stages and bubbles are sent downstream.

## Interface
Parameters:
- `MULDIV_CYCLES`, default 32: iterations of the mul/div unit; must equal the data width.

Ports:
- `clock`  in  1  pipeline clock; all state updates on the falling edge, as in every Lapido pipeline register.
- `reset`  in  1  asynchronous, active-high reset.
- `registerFileDataA`, `registerFileDataB`  in  32 each  operands from ID/EX.
- `registerFileWrite`  in  4  destination register index.
- `pcpp`  in  32  PC+4 of the instruction.
- `extendedSignal`  in  32  sign-extended immediate.
- `ALUOp`  in  5  operation code.
- `ALUSrc`  in  1  operand B select: 1 = `extendedSignal`, 0 = `registerFileDataB`.
- `memRead`, `memWrite`, `regWrite`, `branch`, `jumpRegister`  in  1 each  control bits.
- `memToReg`  in  2  writeback select.
- `aluResult_out`  out  32  registered result.
- `storeData_out`  out  32  registered `registerFileDataB`.
- `registerFileWrite_out`  out  4; `memToReg_out`  out  2; `memRead_out`, `memWrite_out`, `regWrite_out`  out  1 each.
- `branchTaken_out`  out  1; `branchTarget_out`  out  32  registered redirect.
- `stall`  out  1  combinational; freezes PC, IF/ID and ID/EX.

## Operation
- Operand B is `extendedSignal` when `ALUSrc`=1, else `registerFileDataB`.
- `ALUOp` codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA; shift amount is B[4:0].
  - 11 LUI (result = B<<16).
  - 12 MUL (low 32 bits), 13 DIV (signed), 14 DIVU, 15 REM (signed, sign of dividend).
  - 16–31: result 0.
- All arithmetic is 32-bit wrap-around; no overflow flag.
- Divide corner cases:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - 0x80000000 / −1: quotient 0x80000000, remainder 0.
- Branch and jump:
  - Taken when `jumpRegister`=1 (target = A), or when `branch`=1 and A == `registerFileDataB` (target = `pcpp` + (`extendedSignal`<<2)).
  - `jumpRegister` has priority over `branch`.
  - When not taken, `branchTarget_out` = `pcpp`.
- Flushing younger instructions on a taken redirect is handled upstream; this block does not flush.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if `ALUOp` is in 12–15, `stall`=1. The edge latches operands, clears the counter and moves to BUSY.
  - BUSY: `stall`=1; one iteration per edge. The edge with counter = `MULDIV_CYCLES`−1 moves to DONE.
  - DONE: `stall`=0. The edge captures the mul/div result into the output register and returns to IDLE.
- Output register update, every falling edge:
  - When `stall`=0: capture the computed values.
  - When `stall`=1: capture a bubble (all `_out` signals 0).
- Reset: state IDLE, counter 0, every output register 0, `stall` 0. Reset asserted mid-BUSY aborts the operation; no result is produced.

## Timing
- Single-cycle ops: result appears on the `_out` ports after the first falling edge following input presentation. Latency 1, no stall.
- Mul/div:
  - `stall` is high for `MULDIV_CYCLES`+1 cycles (33 by default).
  - The result is registered on the edge that ends DONE: `MULDIV_CYCLES`+2 edges after first presentation.
  - Exactly one bubble is emitted per stalled cycle.
- ID/EX must hold its contents while `stall`=1. The block relies on this: operands latched in IDLE stay valid on the inputs through DONE.
- Back-to-back mul/div: the second op is first seen in IDLE after DONE, so no cycle is shared.
- Branch fields are registered with the result, so the redirect is visible one edge after EX.

## Structure
- Shared include `lapido_defs.vh`: ALUOp code localparams (0–15), FSM state encodings, data width 32.
- Sub-module `mul_div_unit`:
  - Iterative shift-add multiplier and restoring divider.
  - Holds operand/result registers and the iteration counter.
  - Handshake: `start`/`busy`/`done`.
  - Sign handling: operands converted to magnitudes on start; signs fixed at done.
- `ex_stage` holds the combinational ALU, branch logic, FSM glue and output register.

## Test plan
- ADD 0x7FFFFFFF + 1, `ALUSrc`=0 → `aluResult_out`=0x80000000 after 1 edge; `stall` never asserts.
- SRA 0x80000000 by B=0x24 (shift 4) → 0xF8000000. SLT −1 vs 1 → 1; SLTU −1 vs 1 → 0.
- MUL 0xFFFFFFFF × 3:
  - `stall` high exactly 33 cycles with 33 bubbles (`regWrite_out`=0).
  - Then `aluResult_out`=0xFFFFFFFD with `regWrite_out`=1.
- DIV 7 / 0 → 0xFFFFFFFF. REM −7 / 2 → 0xFFFFFFFF (−1). DIV 0x80000000 / −1 → 0x80000000.
- `branch`=1, A=B=5, `pcpp`=0x100, imm=−2 → `branchTaken_out`=1, target 0xF8. The same with `jumpRegister`=1, A=0x400 → target 0x400.
- Assert `reset` on the 10th BUSY cycle of a DIV → all outputs 0 immediately, `stall`=0. After release, a following ADD completes in 1 edge.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU opcodes, mul/div types and the EX/MEM payload for the Lapido execute stage.
package ex_stage_pkg;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned ALU_OP_W     = 5;
  localparam int unsigned REG_IDX_W    = 4;
  localparam int unsigned MEM_TO_REG_W = 2;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 5'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 5'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 5'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'd10;
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = 5'd11;
  localparam logic [ALU_OP_W-1:0] ALU_MUL  = 5'd12;
  localparam logic [ALU_OP_W-1:0] ALU_DIV  = 5'd13;
  localparam logic [ALU_OP_W-1:0] ALU_DIVU = 5'd14;
  localparam logic [ALU_OP_W-1:0] ALU_REM  = 5'd15;

  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_e;
  // Encoded so that the low two ALUOp bits of codes 12..15 select the operation.
  typedef enum logic [1:0] {MD_MUL = 2'd0, MD_DIV = 2'd1, MD_DIVU = 2'd2, MD_REM = 2'd3} md_op_e;

  typedef struct packed {
    logic [XLEN-1:0]         alu_result;
    logic [XLEN-1:0]         store_data;
    logic [REG_IDX_W-1:0]    reg_write_idx;
    logic [MEM_TO_REG_W-1:0] mem_to_reg;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic                    branch_taken;
    logic [XLEN-1:0]         branch_target;
  } ex_mem_t;

  function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REM);
  endfunction
endpackage

// File: rtl/ex_stage_mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider; one iteration per falling clock edge.
module mul_div_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result_c
);
  localparam int unsigned CNT_W = $clog2(MULDIV_CYCLES);

  md_state_e        state_q;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  work_q;      // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]  opnd_q;      // multiplier, or divisor magnitude
  logic [XLEN-1:0]  acc_q;       // product, or partial remainder
  logic [XLEN-1:0]  dividend_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic             div_zero_q;
  logic             signed_op;
  logic [XLEN:0]    rem_shift;
  logic             rem_fits;
  logic [XLEN-1:0]  rem_next;

  assign signed_op = (op == MD_DIV) || (op == MD_REM);
  assign rem_shift = {acc_q, work_q[XLEN-1]};
  assign rem_fits  = rem_shift >= {1'b0, opnd_q};
  assign rem_next  = rem_fits ? XLEN'(rem_shift - {1'b0, opnd_q}) : rem_shift[XLEN-1:0];

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= MD_IDLE;
      op_q       <= MD_MUL;
      cnt_q      <= '0;
      work_q     <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      dividend_q <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            op_q       <= op;
            work_q     <= (signed_op && a[XLEN-1]) ? -a : a;
            opnd_q     <= (signed_op && b[XLEN-1]) ? -b : b;
            acc_q      <= '0;
            cnt_q      <= '0;
            dividend_q <= a;
            quo_neg_q  <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
            rem_neg_q  <= signed_op && a[XLEN-1];
            div_zero_q <= (b == '0);
            busy       <= 1'b1;
            state_q    <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (op_q == MD_MUL) begin
            if (opnd_q[0]) acc_q <= acc_q + work_q;
            work_q <= work_q << 1;
            opnd_q <= opnd_q >> 1;
          end else begin
            acc_q  <= rem_next;
            work_q <= {work_q[XLEN-2:0], rem_fits};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MULDIV_CYCLES - 1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= MD_DONE;
          end
        end
        MD_DONE: begin
          done    <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  // Signs and divide-by-zero results are applied to the magnitudes once iteration is over.
  always_comb begin
    result_c = acc_q;
    case (op_q)
      MD_DIV, MD_DIVU: result_c = div_zero_q ? '1 : (quo_neg_q ? -work_q : work_q);
      MD_REM:          result_c = div_zero_q ? dividend_q : (rem_neg_q ? -acc_q : acc_q);
      default:         result_c = acc_q;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// Lapido execute stage: ALU, branch/jump resolution, mul/div sequencing and EX/MEM output register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [XLEN-1:0]         registerFileDataA,
  input  logic [XLEN-1:0]         registerFileDataB,
  input  logic [REG_IDX_W-1:0]    registerFileWrite,
  input  logic [XLEN-1:0]         pcpp,
  input  logic [XLEN-1:0]         extendedSignal,
  input  logic [ALU_OP_W-1:0]     ALUOp,
  input  logic                    ALUSrc,
  input  logic                    memRead,
  input  logic                    memWrite,
  input  logic                    regWrite,
  input  logic                    branch,
  input  logic                    jumpRegister,
  input  logic [MEM_TO_REG_W-1:0] memToReg,
  output logic [XLEN-1:0]         aluResult_out,
  output logic [XLEN-1:0]         storeData_out,
  output logic [REG_IDX_W-1:0]    registerFileWrite_out,
  output logic [MEM_TO_REG_W-1:0] memToReg_out,
  output logic                    memRead_out,
  output logic                    memWrite_out,
  output logic                    regWrite_out,
  output logic                    branchTaken_out,
  output logic [XLEN-1:0]         branchTarget_out,
  output logic                    stall
);
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_c;
  logic [XLEN-1:0] md_result;
  logic            md_op;
  logic            md_start;
  logic            md_busy;
  logic            md_done;
  logic            branch_taken_c;
  logic [XLEN-1:0] branch_target_c;
  ex_mem_t         next_c;
  ex_mem_t         out_q;

  assign op_b  = ALUSrc ? extendedSignal : registerFileDataB;
  assign shamt = op_b[4:0];
  assign md_op = is_muldiv(ALUOp);

  // The launch cycle (unit idle) and every iteration stall; the DONE cycle lets the result through.
  assign md_start = md_op && !md_busy && !md_done;
  assign stall    = !reset && (md_busy || md_start);

  mul_div_unit #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_mul_div (
    .clock   (clock),
    .reset   (reset),
    .start   (md_start),
    .op      (md_op_e'(ALUOp[1:0])),
    .a       (registerFileDataA),
    .b       (op_b),
    .busy    (md_busy),
    .done    (md_done),
    .result_c(md_result)
  );

  always_comb begin
    alu_c = '0;
    case (ALUOp)
      ALU_ADD:  alu_c = registerFileDataA + op_b;
      ALU_SUB:  alu_c = registerFileDataA - op_b;
      ALU_AND:  alu_c = registerFileDataA & op_b;
      ALU_OR:   alu_c = registerFileDataA | op_b;
      ALU_XOR:  alu_c = registerFileDataA ^ op_b;
      ALU_NOR:  alu_c = ~(registerFileDataA | op_b);
      ALU_SLT:  alu_c = {{(XLEN-1){1'b0}}, $signed(registerFileDataA) < $signed(op_b)};
      ALU_SLTU: alu_c = {{(XLEN-1){1'b0}}, registerFileDataA < op_b};
      ALU_SLL:  alu_c = registerFileDataA << shamt;
      ALU_SRL:  alu_c = registerFileDataA >> shamt;
      ALU_SRA:  alu_c = XLEN'($signed(registerFileDataA) >>> shamt);
      ALU_LUI:  alu_c = op_b << 16;
      ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM: alu_c = md_result;
      default:  alu_c = '0;
    endcase
  end

  // Register-indirect jump wins over a conditional branch.
  always_comb begin
    branch_taken_c  = 1'b0;
    branch_target_c = pcpp;
    if (jumpRegister) begin
      branch_taken_c  = 1'b1;
      branch_target_c = registerFileDataA;
    end else if (branch && (registerFileDataA == registerFileDataB)) begin
      branch_taken_c  = 1'b1;
      branch_target_c = pcpp + (extendedSignal << 2);
    end
  end

  always_comb begin
    next_c               = '0;
    next_c.alu_result    = alu_c;
    next_c.store_data    = registerFileDataB;
    next_c.reg_write_idx = registerFileWrite;
    next_c.mem_to_reg    = memToReg;
    next_c.mem_read      = memRead;
    next_c.mem_write     = memWrite;
    next_c.reg_write     = regWrite;
    next_c.branch_taken  = branch_taken_c;
    next_c.branch_target = branch_target_c;
  end

  // A stalled cycle sends an all-zero bubble downstream.
  always_ff @(negedge clock or posedge reset) begin
    if (reset)      out_q <= '0;
    else if (stall) out_q <= '0;
    else            out_q <= next_c;
  end

  assign aluResult_out         = out_q.alu_result;
  assign storeData_out         = out_q.store_data;
  assign registerFileWrite_out = out_q.reg_write_idx;
  assign memToReg_out          = out_q.mem_to_reg;
  assign memRead_out           = out_q.mem_read;
  assign memWrite_out          = out_q.mem_write;
  assign regWrite_out          = out_q.reg_write;
  assign branchTaken_out       = out_q.branch_taken;
  assign branchTarget_out      = out_q.branch_target;
endmodule
